// File: rtl/adc_ltc2308_seq.sv
// rtl/adc_ltc2308_seq.sv - LTC2308 conversion sequencer and serial engine
//
// Purpose: accepts burst commands (channel, mode, count), runs CONVST/SCK/SDI
// frames against an LTC2308, deserialises SDO and emits tagged samples on a
// valid/ready stream. The ADC applies a config word one frame late, so a
// priming frame is inserted whenever the ADC does not already hold the
// requested word; its result is discarded.
//
// Ports:
//   clock, reset_in                      single clock, synchronous active-high reset
//   cmd_valid/cmd_ready                  command handshake (ready only in IDLE)
//   cmd_channel/cmd_single/cmd_unipolar  requested channel and mode
//   cmd_count                            samples to take (0 = no frame)
//   smp_valid/smp_ready                  sample handshake
//   smp_data/smp_channel/smp_last        sample, channel tag, final-of-burst flag
//   busy                                 sequencer not IDLE
//   ADC_CONVST_o/ADC_SCK_o/ADC_SDI_o     ADC control outputs (registered)
//   ADC_SDO_i                            ADC serial data in
module adc_ltc2308_seq #(
    parameter int SCK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int ACQ_CYCLES  = 13,
    parameter int CNT_W       = 12
) (
    input  logic             clock,
    input  logic             reset_in,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_channel,
    input  logic             cmd_single,
    input  logic             cmd_unipolar,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [11:0]      smp_data,
    output logic [2:0]       smp_channel,
    output logic             smp_last,
    output logic             busy,
    output logic             ADC_CONVST_o,
    output logic             ADC_SCK_o,
    output logic             ADC_SDI_o,
    input  logic             ADC_SDO_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CONV = 3'd1;
    localparam logic [2:0] S_XFER = 3'd2;
    localparam logic [2:0] S_ACQ  = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;
    localparam logic [2:0] S_NONE = 3'd5;   // one-clock pass-through for count = 0

    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0] CONV_LAST = TMR_W'(CONV_CYCLES - 1);
    localparam logic [TMR_W-1:0] ACQ_LAST  = TMR_W'(ACQ_CYCLES - 1);
    localparam logic [TMR_W-1:0] PH_LAST   = TMR_W'(SCK_DIV - 1);

    logic [2:0]       state;
    logic [TMR_W-1:0] tmr;
    logic [3:0]       bit_cnt;
    logic [4:0]       sdi_sr;
    logic [10:0]      rx_sr;
    logic             sdo_r;
    logic [5:0]       cur_word;
    logic [2:0]       cur_ch;
    logic [CNT_W-1:0] left;
    logic             priming;
    logic [5:0]       cfg_loaded;
    logic             cfg_ok;
    logic             convst;
    logic             sck;
    logic             sdi;
    logic [5:0]       req_word;

    // LTC2308 config word: S/D, O/S, S1, S0, UNI, SLP
    assign req_word = {cmd_single, cmd_channel[0], cmd_channel[2], cmd_channel[1],
                       cmd_unipolar, 1'b0};

    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign smp_valid    = (state == S_EMIT);
    assign ADC_CONVST_o = convst;
    assign ADC_SCK_o    = sck;
    assign ADC_SDI_o    = sdi;

    always_ff @(posedge clock) begin
        if (reset_in) begin
            state       <= S_IDLE;
            tmr         <= '0;
            bit_cnt     <= '0;
            sdi_sr      <= '0;
            rx_sr       <= '0;
            sdo_r       <= 1'b0;
            cur_word    <= '0;
            cur_ch      <= '0;
            left        <= '0;
            priming     <= 1'b0;
            cfg_loaded  <= '0;
            cfg_ok      <= 1'b0;
            convst      <= 1'b0;
            sck         <= 1'b0;
            sdi         <= 1'b0;
            smp_data    <= '0;
            smp_channel <= '0;
            smp_last    <= 1'b0;
        end else begin
            sdo_r <= ADC_SDO_i;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur_word <= req_word;
                        cur_ch   <= cmd_channel;
                        left     <= cmd_count;
                        if (cmd_count == '0) begin
                            state <= S_NONE;
                        end else begin
                            state   <= S_CONV;
                            convst  <= 1'b1;
                            tmr     <= '0;
                            // ADC must already hold this word, otherwise the
                            // first frame only loads it and its data is dropped
                            priming <= !cfg_ok || (cfg_loaded != req_word);
                        end
                    end
                end
                S_NONE: begin
                    state <= S_IDLE;
                end
                S_CONV: begin
                    if (tmr == CONV_LAST) begin
                        state   <= S_XFER;
                        convst  <= 1'b0;
                        tmr     <= '0;
                        bit_cnt <= '0;
                        sdi     <= cur_word[5];
                        sdi_sr  <= cur_word[4:0];
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_XFER: begin
                    if (tmr == PH_LAST) begin
                        tmr <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            // falling SCK: capture SDO, present next config bit
                            sck     <= 1'b0;
                            sdi     <= sdi_sr[4];
                            sdi_sr  <= {sdi_sr[3:0], 1'b0};
                            rx_sr   <= {rx_sr[9:0], sdo_r};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd11) begin
                                state      <= S_ACQ;
                                sdi        <= 1'b0;
                                cfg_loaded <= cur_word;
                                cfg_ok     <= 1'b1;
                                if (!priming) begin
                                    smp_data    <= {rx_sr, sdo_r};
                                    smp_channel <= cur_ch;
                                    smp_last    <= (left == CNT_W'(1));
                                end
                            end
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_ACQ: begin
                    if (tmr == ACQ_LAST) begin
                        tmr <= '0;
                        if (priming) begin
                            priming <= 1'b0;
                            state   <= S_CONV;
                            convst  <= 1'b1;
                        end else begin
                            state <= S_EMIT;
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_EMIT: begin
                    if (smp_ready) begin
                        if (left == CNT_W'(1)) begin
                            state <= S_IDLE;
                        end else begin
                            left   <= left - CNT_W'(1);
                            state  <= S_CONV;
                            convst <= 1'b1;
                            tmr    <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_ltc2308_seq.sv
// tb/tb_adc_ltc2308_seq.sv - directed self-checking bench for adc_ltc2308_seq
module tb_adc_ltc2308_seq;

    logic        clock = 1'b0;
    logic        reset_in = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_channel = '0;
    logic        cmd_single = 1'b0;
    logic        cmd_unipolar = 1'b0;
    logic [11:0] cmd_count = '0;
    logic        smp_valid;
    logic        smp_ready = 1'b1;
    logic [11:0] smp_data;
    logic [2:0]  smp_channel;
    logic        smp_last;
    logic        busy;
    logic        ADC_CONVST_o;
    logic        ADC_SCK_o;
    logic        ADC_SDI_o;
    logic        ADC_SDO_i = 1'b0;

    always #5 clock = ~clock;

    adc_ltc2308_seq dut (
        .clock        (clock),
        .reset_in     (reset_in),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_channel  (cmd_channel),
        .cmd_single   (cmd_single),
        .cmd_unipolar (cmd_unipolar),
        .cmd_count    (cmd_count),
        .smp_valid    (smp_valid),
        .smp_ready    (smp_ready),
        .smp_data     (smp_data),
        .smp_channel  (smp_channel),
        .smp_last     (smp_last),
        .busy         (busy),
        .ADC_CONVST_o (ADC_CONVST_o),
        .ADC_SCK_o    (ADC_SCK_o),
        .ADC_SDI_o    (ADC_SDI_o),
        .ADC_SDO_i    (ADC_SDO_i)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ADC model and bus monitor
    logic [11:0] adc_word = 12'h000;
    int          sdo_idx = 11;
    logic        prev_conv = 1'b0;
    logic        prev_sck = 1'b0;
    int          rise_t = 0;
    int          sdi_n = 0;
    logic [11:0] sdi_sh = '0;
    int          sck_rises = 0;
    int          conv_rise[$];
    int          conv_w[$];
    logic [11:0] sdi_words[$];
    logic [11:0] s_data[$];
    logic [2:0]  s_ch[$];
    logic        s_last[$];
    int          s_t[$];

    always @(negedge clock) begin
        if (!prev_conv && ADC_CONVST_o) begin
            conv_rise.push_back(cyc);
            rise_t = cyc;
            sdi_n  = 0;
        end
        if (prev_conv && !ADC_CONVST_o) begin
            conv_w.push_back(cyc - rise_t);
            sdo_idx = 11;
        end else if (prev_sck && !ADC_SCK_o && sdo_idx > 0) begin
            sdo_idx = sdo_idx - 1;
        end
        if (!prev_sck && ADC_SCK_o) begin
            sck_rises = sck_rises + 1;
            sdi_sh = {sdi_sh[10:0], ADC_SDI_o};
            sdi_n = sdi_n + 1;
            if (sdi_n == 12) sdi_words.push_back(sdi_sh);
        end
        if (smp_valid && smp_ready) begin
            s_data.push_back(smp_data);
            s_ch.push_back(smp_channel);
            s_last.push_back(smp_last);
            s_t.push_back(cyc);
        end
        ADC_SDO_i = adc_word[sdo_idx];
        prev_conv = ADC_CONVST_o;
        prev_sck  = ADC_SCK_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        conv_rise.delete();
        conv_w.delete();
        sdi_words.delete();
        s_data.delete();
        s_ch.delete();
        s_last.delete();
        s_t.delete();
        sck_rises = 0;
    endtask

    task automatic send_cmd(input logic [2:0] ch, input logic sgl, input logic uni,
                            input logic [11:0] cnt);
        @(posedge clock);
        #1;
        cmd_channel  = ch;
        cmd_single   = sgl;
        cmd_unipolar = uni;
        cmd_count    = cnt;
        cmd_valid    = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", busy, 0);
        repeat (5) @(negedge clock);
    endtask

    initial begin
        int n;
        int bad;
        logic [11:0] held;
        logic held_last;

        repeat (4) @(posedge clock);
        #1;
        reset_in = 1'b0;
        @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_smp_valid", smp_valid, 0);
        chk("rst_smp_data", smp_data, 0);
        chk("rst_smp_channel", smp_channel, 0);
        chk("rst_smp_last", smp_last, 0);
        chk("rst_convst", ADC_CONVST_o, 0);
        chk("rst_sck", ADC_SCK_o, 0);
        chk("rst_sdi", ADC_SDI_o, 0);
        repeat (1000) @(negedge clock);
        chk("quiet_conv", conv_rise.size(), 0);
        chk("quiet_sck", sck_rises, 0);

        // first command: ch5 single unipolar, priming frame expected
        clear_mon();
        adc_word = 12'hA5C;
        send_cmd(3'd5, 1'b1, 1'b1, 12'd1);
        @(negedge clock);
        chk("acc_cmd_ready", cmd_ready, 0);
        chk("acc_busy", busy, 1);
        chk("acc_convst", ADC_CONVST_o, 1);
        wait_idle(600);
        chk("b1_nconv", conv_rise.size(), 2);
        chk("b1_w0", conv_w[0], 80);
        chk("b1_w1", conv_w[1], 80);
        chk("b1_sdi0", sdi_words[0], 12'hE80);
        chk("b1_sdi1", sdi_words[1], 12'hE80);
        chk("b1_nsmp", s_data.size(), 1);
        chk("b1_data", s_data[0], 12'hA5C);
        chk("b1_ch", s_ch[0], 5);
        chk("b1_last", s_last[0], 1);
        chk("b1_ready", cmd_ready, 1);

        // same config, count 3: no priming, 142-clock frames
        clear_mon();
        adc_word = 12'h3C7;
        send_cmd(3'd5, 1'b1, 1'b1, 12'd3);
        wait_idle(800);
        chk("b2_nconv", conv_rise.size(), 3);
        chk("b2_gap0", conv_rise[1] - conv_rise[0], 142);
        chk("b2_gap1", conv_rise[2] - conv_rise[1], 142);
        chk("b2_nsmp", s_data.size(), 3);
        chk("b2_data2", s_data[2], 12'h3C7);
        chk("b2_ch1", s_ch[1], 5);
        chk("b2_last0", s_last[0], 0);
        chk("b2_last1", s_last[1], 0);
        chk("b2_last2", s_last[2], 1);

        // ch2 differential bipolar: new config, priming again
        clear_mon();
        adc_word = 12'h5A5;
        send_cmd(3'd2, 1'b0, 1'b0, 12'd1);
        wait_idle(600);
        chk("b3_nconv", conv_rise.size(), 2);
        chk("b3_sdi0", sdi_words[0], 12'h100);
        chk("b3_sdi1", sdi_words[1], 12'h100);
        chk("b3_nsmp", s_data.size(), 1);
        chk("b3_data", s_data[0], 12'h5A5);
        chk("b3_ch", s_ch[0], 2);

        // backpressure during a count-2 burst
        clear_mon();
        adc_word = 12'h6B1;
        smp_ready = 1'b0;
        send_cmd(3'd2, 1'b0, 1'b0, 12'd2);
        n = 0;
        while (!smp_valid && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("bp_valid", smp_valid, 1);
        held = smp_data;
        held_last = smp_last;
        bad = 0;
        repeat (300) begin
            @(negedge clock);
            if (!smp_valid || smp_data !== held || smp_last !== held_last) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_no_conv", conv_rise.size(), 1);
        chk("bp_data", held, 12'h6B1);
        chk("bp_last0", held_last, 0);
        @(posedge clock);
        #1;
        smp_ready = 1'b1;
        wait_idle(600);
        chk("bp_nsmp", s_data.size(), 2);
        chk("bp_conv_after_hs", conv_rise[1] - s_t[0], 1);
        chk("bp_last1", s_last[1], 1);

        // count = 0
        clear_mon();
        send_cmd(3'd1, 1'b1, 1'b0, 12'd0);
        @(negedge clock);
        chk("z_ready_t1", cmd_ready, 0);
        @(negedge clock);
        chk("z_ready_t2", cmd_ready, 1);
        repeat (50) @(negedge clock);
        chk("z_nconv", conv_rise.size(), 0);
        chk("z_nsck", sck_rises, 0);
        chk("z_nsmp", s_data.size(), 0);

        // reset mid-XFER, then repeat the command
        clear_mon();
        adc_word = 12'h777;
        send_cmd(3'd2, 1'b0, 1'b0, 12'd1);
        n = 0;
        while (!ADC_SCK_o && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("r_sck_seen", ADC_SCK_o, 1);
        reset_in = 1'b1;
        @(posedge clock);
        #1;
        reset_in = 1'b0;
        chk("r_sck_low", ADC_SCK_o, 0);
        chk("r_convst_low", ADC_CONVST_o, 0);
        chk("r_sdi_low", ADC_SDI_o, 0);
        repeat (200) @(negedge clock);
        chk("r_no_smp", s_data.size(), 0);
        chk("r_ready", cmd_ready, 1);
        clear_mon();
        send_cmd(3'd2, 1'b0, 1'b0, 12'd1);
        wait_idle(600);
        chk("r2_nconv", conv_rise.size(), 2);
        chk("r2_nsmp", s_data.size(), 1);
        chk("r2_data", s_data[0], 12'h777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
